// File: rtl/fifo_tx_arbiter_pkg.sv
// Shared encodings and defaults for the UART TX FIFO push-port arbiter.
package fifo_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  localparam int DEF_MAX_LEN = 32;
  localparam int DEF_IDLE_TO = 1000;

  // Pointer value after releasing a grant: favour the requester that was not
  // just served (pointer 0 favours requester 0, pointer 1 favours requester 1).
  function automatic logic nextFavour(input logic [1:0] gnt);
    return gnt[0];
  endfunction

endpackage

// File: rtl/fifo_tx_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester the pointer favours.
module fifo_tx_arbiter_rr_arb2
  import fifo_tx_arbiter_pkg::*;
(
  input  logic [1:0] iReq,
  input  logic       iPtr,
  output logic [1:0] oPick
);

  // Resolve the request pair into a one-hot pick.
  always_comb begin
    oPick = GNT_NONE;
    if (iReq == 2'b11) begin
      oPick = iPtr ? GNT_1 : GNT_0;
    end else if (iReq[0]) begin
      oPick = GNT_0;
    end else if (iReq[1]) begin
      oPick = GNT_1;
    end
  end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the UART TX FIFO push port between
// two byte-stream requesters. A grant is held until end-of-packet, a length
// guard, or an idle timeout releases it.
module fifo_tx_arbiter
  import fifo_tx_arbiter_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IDLE_TO = DEF_IDLE_TO
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iReq0_Valid,
  input  logic [7:0] iReq0_Data,
  input  logic       iReq0_Last,
  output logic       oReq0_Ready,
  input  logic       iReq1_Valid,
  input  logic [7:0] iReq1_Data,
  input  logic       iReq1_Last,
  output logic       oReq1_Ready,
  input  logic       iFull,
  output logic       oPush,
  output logic [7:0] oWrData,
  output logic [1:0] oGrant,
  output logic       oBusy,
  output logic       oOverrun,
  output logic       oTimeout
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(IDLE_TO + 1);
  localparam logic [BW-1:0] MAX_CNT  = BW'(MAX_LEN);
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_TO);

  state_t        state, stateNext;
  logic [1:0]    grant, grantNext, pick;
  logic          ptr, ptrNext;
  logic [BW-1:0] byteCnt, byteCntNext, byteInc;
  logic [IW-1:0] idleCnt, idleCntNext, idleInc;
  logic          overrun, overrunNext;
  logic          timeout, timeoutNext;
  logic          gntValid, gntLast, xferPush, inXfer;
  logic [7:0]    gntData;

  fifo_tx_arbiter_rr_arb2 uPicker (
    .iReq  ({iReq1_Valid, iReq0_Valid}),
    .iPtr  (ptr),
    .oPick (pick)
  );

  // Select the granted requester's stream; with no grant everything reads zero.
  always_comb begin
    gntValid = 1'b0;
    gntLast  = 1'b0;
    gntData  = '0;
    if (grant == GNT_0) begin
      gntValid = iReq0_Valid;
      gntLast  = iReq0_Last;
      gntData  = iReq0_Data;
    end else if (grant == GNT_1) begin
      gntValid = iReq1_Valid;
      gntLast  = iReq1_Last;
      gntData  = iReq1_Data;
    end
  end

  assign inXfer   = (state == ST_XFER);
  assign xferPush = inXfer & gntValid & ~iFull;
  assign byteInc  = byteCnt + BW'(1);
  assign idleInc  = idleCnt + IW'(1);

  assign oReq0_Ready = inXfer & grant[0] & ~iFull;
  assign oReq1_Ready = inXfer & grant[1] & ~iFull;
  assign oPush       = xferPush;
  assign oWrData     = gntData;
  assign oGrant      = grant;
  assign oBusy       = inXfer;
  assign oOverrun    = overrun;
  assign oTimeout    = timeout;

  // Arbitration, packet tracking and release decisions.
  always_comb begin
    stateNext   = state;
    grantNext   = grant;
    ptrNext     = ptr;
    byteCntNext = byteCnt;
    idleCntNext = idleCnt;
    overrunNext = 1'b0;
    timeoutNext = 1'b0;
    case (state)
      ST_IDLE: begin
        // Full FIFO does not hold off arbitration, only the pushes.
        if (pick != GNT_NONE) begin
          stateNext   = ST_XFER;
          grantNext   = pick;
          byteCntNext = '0;
          idleCntNext = '0;
        end
      end
      ST_XFER: begin
        if (xferPush) begin
          byteCntNext = byteInc;
          idleCntNext = '0;
          // Last on the MAX_LEN-th byte is a clean end, not an overrun.
          if (gntLast || (byteInc == MAX_CNT)) begin
            stateNext   = ST_IDLE;
            grantNext   = GNT_NONE;
            ptrNext     = nextFavour(grant);
            overrunNext = ~gntLast;
          end
        end else if (gntValid) begin
          // Stalled by a full FIFO: the requester is alive, so no timeout.
          idleCntNext = '0;
        end else if (idleInc == IDLE_LIM) begin
          stateNext   = ST_IDLE;
          grantNext   = GNT_NONE;
          ptrNext     = nextFavour(grant);
          timeoutNext = 1'b1;
        end else begin
          idleCntNext = idleInc;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        grantNext = GNT_NONE;
      end
    endcase
  end

  // State, grant, pointer, counters and release pulses.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= ST_IDLE;
      grant   <= GNT_NONE;
      ptr     <= 1'b0;
      byteCnt <= '0;
      idleCnt <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= stateNext;
      grant   <= grantNext;
      ptr     <= ptrNext;
      byteCnt <= byteCntNext;
      idleCnt <= idleCntNext;
      overrun <= overrunNext;
      timeout <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Self-checking bench for fifo_tx_arbiter: directed scenarios with exact cycle
// expectations, then a randomized run scored against a packet-level model.
module tb_fifo_tx_arbiter;

  localparam int ML = 4;
  localparam int IT = 8;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iReq0_Valid = 1'b0, iReq0_Last = 1'b0;
  logic       iReq1_Valid = 1'b0, iReq1_Last = 1'b0;
  logic [7:0] iReq0_Data = 8'h00, iReq1_Data = 8'h00;
  logic       iFull = 1'b0;
  logic       oReq0_Ready, oReq1_Ready, oPush, oBusy, oOverrun, oTimeout;
  logic [7:0] oWrData;
  logic [1:0] oGrant;

  int nChecks = 0;
  int nErrors = 0;

  // scripted streams and per-run logs
  logic [7:0] d0[$], d1[$];
  logic       l0[$], l1[$];
  logic [9:0] pushLog[$];
  int         pushCyc[$], ovCyc[$], toCyc[$];
  logic [1:0] gntLog[$];
  logic       busyLog[$];
  logic [9:0] expLog[$];

  // random-phase model state
  logic [7:0] q0[$], q1[$];
  logic       ql0[$], ql1[$];
  int         owner, favour, cnt, dly0, dly1;
  bit         acc0, acc1;
  logic       expOv, gv, gl;
  logic [7:0] gd;

  always #5 iClk = ~iClk;

  fifo_tx_arbiter #(.MAX_LEN(ML), .IDLE_TO(IT)) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iReq0_Valid (iReq0_Valid),
    .iReq0_Data  (iReq0_Data),
    .iReq0_Last  (iReq0_Last),
    .oReq0_Ready (oReq0_Ready),
    .iReq1_Valid (iReq1_Valid),
    .iReq1_Data  (iReq1_Data),
    .iReq1_Last  (iReq1_Last),
    .oReq1_Ready (oReq1_Ready),
    .iFull       (iFull),
    .oPush       (oPush),
    .oWrData     (oWrData),
    .oGrant      (oGrant),
    .oBusy       (oBusy),
    .oOverrun    (oOverrun),
    .oTimeout    (oTimeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic toNeg();
    @(negedge iClk);
  endtask

  task automatic drv0(input logic v, input logic [7:0] d, input logic l);
    iReq0_Valid = v; iReq0_Data = d; iReq0_Last = l;
  endtask

  task automatic drv1(input logic v, input logic [7:0] d, input logic l);
    iReq1_Valid = v; iReq1_Data = d; iReq1_Last = l;
  endtask

  task automatic doReset();
    nextCyc();
    iRst_n = 1'b0;
    drv0(1'b0, 8'h00, 1'b0);
    drv1(1'b0, 8'h00, 1'b0);
    iFull = 1'b0;
    nextCyc();
    iRst_n = 1'b1;
  endtask

  task automatic clr();
    d0.delete(); d1.delete(); l0.delete(); l1.delete();
    pushLog.delete(); pushCyc.delete(); ovCyc.delete(); toCyc.delete();
    gntLog.delete(); busyLog.delete(); expLog.delete();
  endtask

  // Each requester presents its scripted bytes from its start cycle, holding
  // each byte until accepted, and drops Valid once its script is exhausted.
  task automatic runStreams(input int nCyc, input int st0, input int st1,
                            input int fullFrom, input int fullTo);
    int i0 = 0;
    int i1 = 0;
    bit a0 = 0;
    bit a1 = 0;
    for (int c = 0; c < nCyc; c++) begin
      nextCyc();
      if (a0) i0++;
      if (a1) i1++;
      drv0(c >= st0 && i0 < d0.size(), i0 < d0.size() ? d0[i0] : 8'h00,
           i0 < l0.size() ? l0[i0] : 1'b0);
      drv1(c >= st1 && i1 < d1.size(), i1 < d1.size() ? d1[i1] : 8'h00,
           i1 < l1.size() ? l1[i1] : 1'b0);
      iFull = (c >= fullFrom && c < fullTo);
      toNeg();
      a0 = iReq0_Valid & oReq0_Ready;
      a1 = iReq1_Valid & oReq1_Ready;
      if (oPush) begin
        pushLog.push_back({oGrant, oWrData});
        pushCyc.push_back(c);
      end
      if (oOverrun) ovCyc.push_back(c);
      if (oTimeout) toCyc.push_back(c);
      gntLog.push_back(oGrant);
      busyLog.push_back(oBusy);
      if (iFull) begin
        chk("stall_push", oPush, 1'b0);
        chk("stall_ready", {oReq1_Ready, oReq0_Ready}, 2'b00);
      end
    end
  endtask

  initial begin
    // ---------------- reset values ----------------
    #2;
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_grant", oGrant, 2'b00);
    chk("rst_push", oPush, 1'b0);
    chk("rst_ready", {oReq1_Ready, oReq0_Ready}, 2'b00);
    chk("rst_wrdata", oWrData, 8'h00);
    chk("rst_overrun", oOverrun, 1'b0);
    chk("rst_timeout", oTimeout, 1'b0);
    nextCyc();
    nextCyc();
    iRst_n = 1'b1;

    // ---------------- single packet ----------------
    clr();
    d0 = '{8'h41, 8'h42, 8'h0A};
    l0 = '{1'b0, 1'b0, 1'b1};
    runStreams(6, 0, 1000, -1, -1);
    chk("sp_npush", pushLog.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("sp_byte", pushLog[k], {2'b01, d0[k]});
      chk("sp_cycle", pushCyc[k], k + 1);
    end
    chk("sp_gnt_arb", gntLog[0], 2'b00);
    chk("sp_gnt_xfer", gntLog[1], 2'b01);
    chk("sp_busy_last", busyLog[3], 1'b1);
    chk("sp_busy_drop", busyLog[4], 1'b0);
    chk("sp_no_ov", ovCyc.size(), 0);

    // ---------------- contention from reset ----------------
    doReset();
    clr();
    d0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    l0 = '{1'b0, 1'b1, 1'b0, 1'b1};
    d1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    l1 = '{1'b0, 1'b1, 1'b0, 1'b1};
    expLog = '{10'h1A0, 10'h1A1, 10'h2B0, 10'h2B1, 10'h1A2, 10'h1A3, 10'h2B2, 10'h2B3};
    runStreams(12, 0, 0, -1, -1);
    chk("ct_npush", pushLog.size(), 8);
    for (int k = 0; k < 8; k++) chk("ct_order", pushLog[k], expLog[k]);

    // ---------------- back-pressure mid-packet ----------------
    doReset();
    clr();
    d0 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    l0 = '{1'b0, 1'b0, 1'b0, 1'b1};
    runStreams(19, 0, 1000, 3, 15);
    chk("bp_npush", pushLog.size(), 4);
    for (int k = 0; k < 4; k++) chk("bp_byte", pushLog[k], {2'b01, d0[k]});
    chk("bp_cyc_resume", pushCyc[2], 15);
    chk("bp_cyc_last", pushCyc[3], 16);
    chk("bp_no_timeout", toCyc.size(), 0);
    chk("bp_no_overrun", ovCyc.size(), 0);
    chk("bp_busy_drop", busyLog[17], 1'b0);

    // ---------------- overrun, then idle timeout ----------------
    clr();
    d1 = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    l1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    expLog = '{1, 2, 3, 4, 6, 7};
    runStreams(18, 1000, 0, -1, -1);
    chk("ov_npush", pushLog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("ov_byte", pushLog[k], {2'b10, d1[k]});
      chk("ov_cycle", pushCyc[k], expLog[k]);
    end
    chk("ov_npulse", ovCyc.size(), 1);
    chk("ov_pulse_cyc", ovCyc[0], 5);
    chk("ov_released", gntLog[5], 2'b00);
    chk("ov_to_npulse", toCyc.size(), 1);
    chk("ov_to_cyc", toCyc[0], 16);

    // ---------------- timeout hands over to the pending requester ----------------
    clr();
    d0 = '{8'hE0};
    l0 = '{1'b0};
    d1 = '{8'hF0};
    l1 = '{1'b1};
    runStreams(13, 0, 2, -1, -1);
    chk("to_npush", pushLog.size(), 2);
    chk("to_byte0", pushLog[0], 10'h1E0);
    chk("to_byte1", pushLog[1], 10'h2F0);
    chk("to_npulse", toCyc.size(), 1);
    chk("to_cyc", toCyc[0], 10);
    chk("to_gnt_idle", gntLog[10], 2'b00);
    chk("to_gnt_next", gntLog[11], 2'b10);
    chk("to_push_cyc", pushCyc[1], 11);
    chk("to_busy_drop", busyLog[12], 1'b0);

    // ---------------- asynchronous reset mid-packet ----------------
    clr();
    d0 = '{8'h11};
    l0 = '{1'b1};
    runStreams(3, 0, 1000, -1, -1);
    nextCyc();
    drv0(1'b1, 8'h21, 1'b0);
    drv1(1'b1, 8'h31, 1'b0);
    toNeg();
    chk("ar_idle_gnt", oGrant, 2'b00);
    nextCyc();
    toNeg();
    chk("ar_pre_gnt", oGrant, 2'b10);
    chk("ar_pre_push", oPush, 1'b1);
    #2 iRst_n = 1'b0;
    #1;
    chk("ar_push", oPush, 1'b0);
    chk("ar_grant", oGrant, 2'b00);
    chk("ar_busy", oBusy, 1'b0);
    chk("ar_ready", {oReq1_Ready, oReq0_Ready}, 2'b00);
    chk("ar_wrdata", oWrData, 8'h00);
    nextCyc();
    iRst_n = 1'b1;
    toNeg();
    chk("ar_post_idle", oGrant, 2'b00);
    nextCyc();
    toNeg();
    chk("ar_post_gnt", oGrant, 2'b01);
    chk("ar_post_data", oWrData, 8'h21);

    // ---------------- randomized traffic vs packet-level model ----------------
    doReset();
    q0.delete(); q1.delete(); ql0.delete(); ql1.delete();
    for (int p = 0; p < 10; p++) begin
      int n0, n1;
      n0 = $urandom_range(1, 6);
      n1 = $urandom_range(1, 6);
      for (int b = 0; b < n0; b++) begin
        q0.push_back(8'($urandom));
        ql0.push_back(b == n0 - 1);
      end
      for (int b = 0; b < n1; b++) begin
        q1.push_back(8'($urandom));
        ql1.push_back(b == n1 - 1);
      end
    end
    owner = -1; favour = 0; cnt = 0; expOv = 1'b0;
    acc0 = 0; acc1 = 0; dly0 = 0; dly1 = 0;
    for (int c = 0; c < 4000 && (q0.size() > 0 || q1.size() > 0 || owner >= 0); c++) begin
      nextCyc();
      if (acc0) begin void'(q0.pop_front()); void'(ql0.pop_front()); dly0 = $urandom_range(0, 2); end
      if (acc1) begin void'(q1.pop_front()); void'(ql1.pop_front()); dly1 = $urandom_range(0, 2); end
      if (dly0 > 0) begin dly0--; drv0(1'b0, 8'($urandom), 1'b0); end
      else if (q0.size() > 0) drv0(1'b1, q0[0], ql0[0]);
      else drv0(1'b0, 8'($urandom), 1'b0);
      if (dly1 > 0) begin dly1--; drv1(1'b0, 8'($urandom), 1'b0); end
      else if (q1.size() > 0) drv1(1'b1, q1[0], ql1[0]);
      else drv1(1'b0, 8'($urandom), 1'b0);
      iFull = ($urandom_range(0, 3) == 0);
      toNeg();
      acc0 = 0;
      acc1 = 0;
      if (owner < 0) begin
        chk("rnd_idle_busy", oBusy, 1'b0);
        chk("rnd_idle_gnt", oGrant, 2'b00);
        chk("rnd_idle_push", oPush, 1'b0);
        chk("rnd_idle_ready", {oReq1_Ready, oReq0_Ready}, 2'b00);
        chk("rnd_overrun", oOverrun, expOv);
        chk("rnd_idle_to", oTimeout, 1'b0);
        expOv = 1'b0;
        if (iReq0_Valid || iReq1_Valid) begin
          owner = (iReq0_Valid && iReq1_Valid) ? favour : (iReq0_Valid ? 0 : 1);
          cnt = 0;
        end
      end else begin
        gv = (owner == 0) ? iReq0_Valid : iReq1_Valid;
        gl = (owner == 0) ? iReq0_Last  : iReq1_Last;
        gd = (owner == 0) ? q0[0] : q1[0];
        chk("rnd_gnt", oGrant, ((owner == 0) ? 2'b01 : 2'b10));
        chk("rnd_busy", oBusy, 1'b1);
        chk("rnd_xfer_ov", oOverrun, 1'b0);
        chk("rnd_xfer_to", oTimeout, 1'b0);
        chk("rnd_push", oPush, (gv & ~iFull));
        chk("rnd_ready", {oReq1_Ready, oReq0_Ready},
            ((owner == 0) ? {1'b0, ~iFull} : {~iFull, 1'b0}));
        if (gv && !iFull) begin
          chk("rnd_data", oWrData, gd);
          acc0 = (owner == 0);
          acc1 = (owner == 1);
          cnt++;
          if (gl || cnt == ML) begin
            expOv = !gl;
            favour = 1 - owner;
            owner = -1;
          end
        end
      end
    end
    chk("rnd_drained", (q0.size() + q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
